// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan path: active-low segment patterns,
// digit-enable idle value, scan FSM encoding and the per-digit storage record.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [6:0] SEG_ALL = 7'b0000000;
    localparam logic [3:0] WX_OFF  = 4'b1111;

    typedef enum logic {
        BLANK = 1'b0,
        SCAN  = 1'b1
    } scan_state_e;

    typedef struct packed {
        logic       blank;
        logic [3:0] data;
    } digit_t;

    localparam digit_t DIGIT_DARK = '{blank: 1'b1, data: 4'h0};

    // Active-low one-cold digit enable for the given digit index.
    function automatic logic [3:0] wx_select(input logic [1:0] idx);
        return WX_OFF ^ (4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Digit write port of the scan controller: valid/ready handshake carrying
// a digit index, hex value and per-digit blank flag.
interface seg_scan_ctrl_if;

    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_blank;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        output wr_blank,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        input  wr_blank,
        output wr_ready
    );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex digit to active-low {g,f,e,d,c,b,a} segment decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        unique case (hex_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode display scanner with blanking gaps between digits and
// a shadow digit file that is committed to the displayed set only at frame end.
module seg_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 27000,
    parameter int unsigned ON_TICKS    = 4,
    parameter int unsigned BLANK_TICKS = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    seg_scan_ctrl_if.slave wr,
    input  logic           lamp_test,
    output logic [3:0]     Wx,
    output logic [6:0]     display,
    output logic [1:0]     scan_idx,
    output logic           frame_done
);

    localparam int unsigned PRE_W  = $clog2(TICK_DIV);
    localparam int unsigned PH_MAX = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICK_DIV - 1);
    localparam logic [PH_W-1:0]  ON_LAST    = PH_W'(ON_TICKS - 1);
    localparam logic [PH_W-1:0]  BLANK_LAST = PH_W'(BLANK_TICKS - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    scan_state_e      state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    digit_t [3:0]     shadow_q, shadow_d;
    digit_t [3:0]     active_q, active_d;
    logic             dirty_q, dirty_d;
    logic [3:0]       wx_q, wx_d;
    logic [6:0]       disp_q, disp_d;

    logic             tick;
    logic             commit;
    logic             wr_accept;
    digit_t           cur_digit;
    logic [6:0]       dec_seg;

    assign tick      = (pre_q == PRE_LAST);
    assign cur_digit = active_q[idx_q];

    hex_to_seg7 u_dec (
        .hex_i (cur_digit.data),
        .seg_o (dec_seg)
    );

    // Prescaler and BLANK/SCAN sequencing; commit fires on the last SCAN tick of digit 3.
    always_comb begin
        pre_d   = tick ? '0 : pre_q + 1'b1;
        state_d = state_q;
        ph_d    = ph_q;
        idx_d   = idx_q;
        commit  = 1'b0;
        if (tick) begin
            case (state_q)
                BLANK: begin
                    if (ph_q == BLANK_LAST) begin
                        state_d = SCAN;
                        ph_d    = '0;
                    end else begin
                        ph_d = ph_q + 1'b1;
                    end
                end
                SCAN: begin
                    if (ph_q == ON_LAST) begin
                        state_d = BLANK;
                        ph_d    = '0;
                        idx_d   = idx_q + 2'd1;
                        commit  = (idx_q == 2'd3);
                    end else begin
                        ph_d = ph_q + 1'b1;
                    end
                end
                default: begin
                    state_d = BLANK;
                    ph_d    = '0;
                end
            endcase
        end
    end

    // Writes are refused only on the commit clock so the copy never races a write.
    assign wr.wr_ready = ~commit;
    assign wr_accept   = wr.wr_valid & ~commit;
    assign frame_done  = commit;

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        dirty_d  = dirty_q;
        if (commit) begin
            if (dirty_q) begin
                active_d = shadow_q;
            end
            dirty_d = 1'b0;
        end else if (wr_accept) begin
            shadow_d[wr.wr_addr] = '{blank: wr.wr_blank, data: wr.wr_data};
            dirty_d              = 1'b1;
        end
    end

    // Pin drive follows the registered FSM state one clock later, so a BLANK
    // clock always separates two different enabled digits.
    always_comb begin
        wx_d   = WX_OFF;
        disp_d = SEG_OFF;
        if (state_q == SCAN) begin
            wx_d = wx_select(idx_q);
            if (lamp_test) begin
                disp_d = SEG_ALL;
            end else if (!cur_digit.blank) begin
                disp_d = dec_seg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q    <= '0;
            ph_q     <= '0;
            state_q  <= BLANK;
            idx_q    <= 2'd0;
            shadow_q <= {4{DIGIT_DARK}};
            active_q <= {4{DIGIT_DARK}};
            dirty_q  <= 1'b0;
            wx_q     <= WX_OFF;
            disp_q   <= SEG_OFF;
        end else begin
            pre_q    <= pre_d;
            ph_q     <= ph_d;
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            dirty_q  <= dirty_d;
            wx_q     <= wx_d;
            disp_q   <= disp_d;
        end
    end

    assign Wx       = wx_q;
    assign display  = disp_q;
    assign scan_idx = idx_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with TICK_DIV=4, ON_TICKS=3, BLANK_TICKS=1 (64-clk frame).
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       lamp_test;
    logic [3:0] Wx;
    logic [6:0] display;
    logic [1:0] scan_idx;
    logic       frame_done;

    int checks = 0;
    int errors = 0;
    int e;
    logic [3:0] wx_prev = 4'b1111;

    seg_scan_ctrl_if wr_if ();

    seg_scan_ctrl #(
        .TICK_DIV    (4),
        .ON_TICKS    (3),
        .BLANK_TICKS (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr         (wr_if),
        .lamp_test  (lamp_test),
        .Wx         (Wx),
        .display    (display),
        .scan_idx   (scan_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Edges since reset release: after edge n the bench samples at posedge+1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) e <= 0;
        else        e <= e + 1;
    end

    always @(negedge clk) begin
        if (rst_n && Wx !== wx_prev) begin
            checks++;
            if ((wx_prev !== 4'b1111 && Wx !== 4'b1111) || $countones(~Wx) > 1) begin
                errors++;
                $display("FAIL wx_transition: got %b after %b, required a single low bit entered from 1111", Wx, wx_prev);
            end
        end
        wx_prev = Wx;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic goto(input int n);
        while (e < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        lamp_test      = 1'b0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_addr  = 2'd0;
        wr_if.wr_data  = 4'h0;
        wr_if.wr_blank = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic write_digit(input logic [1:0] a, input logic [3:0] d, input logic b);
        wr_if.wr_addr  = a;
        wr_if.wr_data  = d;
        wr_if.wr_blank = b;
        wr_if.wr_valid = 1'b1;
        @(posedge clk);
        #1;
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        lamp_test      = 1'b0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_addr  = 2'd0;
        wr_if.wr_data  = 4'h0;
        wr_if.wr_blank = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (Wx !== 4'b1111) begin errors++; $display("FAIL reset_wx: got %b required 1111", Wx); end
        checks++; if (display !== 7'b1111111) begin errors++; $display("FAIL reset_display: got %b required 1111111", display); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b required 0", frame_done); end
        checks++; if (scan_idx !== 2'd0) begin errors++; $display("FAIL reset_scan_idx: got %0d required 0", scan_idx); end
        checks++; if (wr_if.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b required 1", wr_if.wr_ready); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle_scan();
        logic [3:0] wexp;
        for (int i = 0; i < 4; i++) begin
            wexp = 4'b1111 ^ (4'b0001 << i);
            goto(5 + 16 * i);
            checks++; if (Wx !== wexp) begin errors++; $display("FAIL idle_wx_start%0d: got %b required %b", i, Wx, wexp); end
            checks++; if (display !== 7'b1111111) begin errors++; $display("FAIL idle_disp%0d: got %b required 1111111", i, display); end
            checks++; if (scan_idx !== 2'(i)) begin errors++; $display("FAIL idle_scan_idx%0d: got %0d required %0d", i, scan_idx, i); end
            if (i == 3) begin
                goto(63);
                checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL idle_frame_done_pulse: got %b required 1", frame_done); end
                checks++; if (wr_if.wr_ready !== 1'b0) begin errors++; $display("FAIL idle_ready_commit: got %b required 0", wr_if.wr_ready); end
            end
            goto(16 + 16 * i);
            checks++; if (Wx !== wexp) begin errors++; $display("FAIL idle_wx_end%0d: got %b required %b", i, Wx, wexp); end
            goto(17 + 16 * i);
            checks++; if (Wx !== 4'b1111) begin errors++; $display("FAIL idle_gap%0d: got %b required 1111", i, Wx); end
            checks++; if (display !== 7'b1111111) begin errors++; $display("FAIL idle_gap_disp%0d: got %b required 1111111", i, display); end
        end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL idle_frame_done_low: got %b required 0", frame_done); end
        checks++; if (scan_idx !== 2'd0) begin errors++; $display("FAIL idle_wrap_idx: got %0d required 0", scan_idx); end
        goto(127);
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL idle_frame_done_2nd: got %b required 1", frame_done); end
        goto(128);
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL idle_frame_done_2nd_end: got %b required 0", frame_done); end
    endtask

    task automatic test_write_commit();
        logic [6:0] exp_seg [4];
        logic [3:0] wexp;
        exp_seg[0] = 7'b1111001;
        exp_seg[1] = 7'b0100100;
        exp_seg[2] = 7'b0110000;
        exp_seg[3] = 7'b0001110;
        do_reset();
        goto(20);
        write_digit(2'd0, 4'h1, 1'b0);
        write_digit(2'd1, 4'h2, 1'b0);
        write_digit(2'd2, 4'h3, 1'b0);
        write_digit(2'd3, 4'hF, 1'b0);
        goto(37);
        checks++; if (display !== 7'b1111111) begin errors++; $display("FAIL wc_same_frame_d2: got %b required 1111111", display); end
        goto(53);
        checks++; if (display !== 7'b1111111) begin errors++; $display("FAIL wc_same_frame_d3: got %b required 1111111", display); end
        for (int i = 0; i < 4; i++) begin
            wexp = 4'b1111 ^ (4'b0001 << i);
            goto(69 + 16 * i);
            checks++; if (Wx !== wexp) begin errors++; $display("FAIL wc_wx%0d: got %b required %b", i, Wx, wexp); end
            checks++; if (display !== exp_seg[i]) begin errors++; $display("FAIL wc_disp%0d: got %b required %b", i, display, exp_seg[i]); end
        end
    endtask

    task automatic test_commit_backpressure();
        do_reset();
        goto(62);
        checks++; if (wr_if.wr_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_before: got %b required 1", wr_if.wr_ready); end
        goto(63);
        checks++; if (wr_if.wr_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_commit: got %b required 0", wr_if.wr_ready); end
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL bp_frame_done: got %b required 1", frame_done); end
        wr_if.wr_addr  = 2'd2;
        wr_if.wr_data  = 4'h5;
        wr_if.wr_blank = 1'b0;
        wr_if.wr_valid = 1'b1;
        goto(64);
        checks++; if (wr_if.wr_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b required 1", wr_if.wr_ready); end
        goto(65);
        wr_if.wr_valid = 1'b0;
        goto(101);
        checks++; if (display !== 7'b1111111) begin errors++; $display("FAIL bp_not_yet: got %b required 1111111", display); end
        goto(165);
        checks++; if (Wx !== 4'b1011) begin errors++; $display("FAIL bp_wx: got %b required 1011", Wx); end
        checks++; if (display !== 7'b0010010) begin errors++; $display("FAIL bp_disp: got %b required 0010010", display); end
    endtask

    task automatic test_last_write_wins();
        do_reset();
        goto(20);
        write_digit(2'd2, 4'h5, 1'b0);
        write_digit(2'd2, 4'h7, 1'b0);
        goto(69);
        checks++; if (display !== 7'b1111111) begin errors++; $display("FAIL lww_unwritten_dark: got %b required 1111111", display); end
        goto(101);
        checks++; if (Wx !== 4'b1011) begin errors++; $display("FAIL lww_wx: got %b required 1011", Wx); end
        checks++; if (display !== 7'b1111000) begin errors++; $display("FAIL lww_disp: got %b required 1111000", display); end
    endtask

    task automatic test_lamp_test();
        do_reset();
        lamp_test = 1'b1;
        goto(5);
        checks++; if (display !== 7'b0000000) begin errors++; $display("FAIL lamp_d0: got %b required 0000000", display); end
        checks++; if (Wx !== 4'b1110) begin errors++; $display("FAIL lamp_wx0: got %b required 1110", Wx); end
        goto(17);
        checks++; if (display !== 7'b1111111) begin errors++; $display("FAIL lamp_gap_disp: got %b required 1111111", display); end
        checks++; if (Wx !== 4'b1111) begin errors++; $display("FAIL lamp_gap_wx: got %b required 1111", Wx); end
        goto(20);
        write_digit(2'd0, 4'h1, 1'b0);
        write_digit(2'd1, 4'h3, 1'b1);
        goto(24);
        checks++; if (display !== 7'b0000000) begin errors++; $display("FAIL lamp_d1_f0: got %b required 0000000", display); end
        goto(85);
        checks++; if (Wx !== 4'b1101) begin errors++; $display("FAIL lamp_wx1_f1: got %b required 1101", Wx); end
        checks++; if (display !== 7'b0000000) begin errors++; $display("FAIL lamp_d1_f1: got %b required 0000000", display); end
        goto(100);
        lamp_test = 1'b0;
        goto(133);
        checks++; if (display !== 7'b1111001) begin errors++; $display("FAIL lamp_off_d0: got %b required 1111001", display); end
        goto(149);
        checks++; if (Wx !== 4'b1101) begin errors++; $display("FAIL blank_wx1: got %b required 1101", Wx); end
        checks++; if (display !== 7'b1111111) begin errors++; $display("FAIL blank_disp1: got %b required 1111111", display); end
    endtask

    task automatic test_reset_midscan();
        do_reset();
        goto(20);
        write_digit(2'd0, 4'h1, 1'b0);
        write_digit(2'd1, 4'h2, 1'b0);
        write_digit(2'd2, 4'h3, 1'b0);
        write_digit(2'd3, 4'hF, 1'b0);
        goto(104);
        checks++; if (Wx !== 4'b1011) begin errors++; $display("FAIL mid_pre_wx: got %b required 1011", Wx); end
        checks++; if (display !== 7'b0110000) begin errors++; $display("FAIL mid_pre_disp: got %b required 0110000", display); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (Wx !== 4'b1111) begin errors++; $display("FAIL mid_async_wx: got %b required 1111", Wx); end
        checks++; if (display !== 7'b1111111) begin errors++; $display("FAIL mid_async_disp: got %b required 1111111", display); end
        checks++; if (scan_idx !== 2'd0) begin errors++; $display("FAIL mid_async_idx: got %0d required 0", scan_idx); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        goto(4);
        checks++; if (Wx !== 4'b1111) begin errors++; $display("FAIL mid_restart_blank: got %b required 1111", Wx); end
        goto(5);
        checks++; if (Wx !== 4'b1110) begin errors++; $display("FAIL mid_restart_wx: got %b required 1110", Wx); end
        checks++; if (display !== 7'b1111111) begin errors++; $display("FAIL mid_lost_d0: got %b required 1111111", display); end
        goto(117);
        checks++; if (Wx !== 4'b0111) begin errors++; $display("FAIL mid_f1_wx3: got %b required 0111", Wx); end
        checks++; if (display !== 7'b1111111) begin errors++; $display("FAIL mid_f1_d3: got %b required 1111111", display); end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_write_commit();
        test_commit_backpressure();
        test_last_write_wins();
        test_lamp_test();
        test_reset_midscan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Scan scheduler for the 4-digit common-anode 7-segment display. It owns the digit-select lines (Wx) and segment lines (display), and time-multiplexes four digits with a dead-time blanking gap between digits to suppress ghosting. Requesters write hex digits into a shadow register file through a valid/ready port. Shadow contents are committed to the displayed set only at frame boundaries, so a frame never shows a torn value. Sits between the application counters/key logic and the board pins.

Parameters:
TICK_DIV, 27000, clk cycles per scan tick (27 MHz -> 1 kHz tick); legal range >= 2
ON_TICKS, 4, ticks a digit is driven per visit; legal range >= 1
BLANK_TICKS, 1, ticks all digits are off before each digit visit; legal range >= 1

Ports:
clk  input  1  system clock
rst_n  input  1  reset
wr_valid  input  1  write request
wr_ready  output  1  write accepted when high with wr_valid
wr_addr  input  2  digit index, 0 = Wx[0]
wr_data  input  4  hex value 0..F
wr_blank  input  1  1 = digit dark
lamp_test  input  1  force all segments on during drive phases
Wx  output  4  digit enables, active-low
display  output  7  segments {g,f,e,d,c,b,a}, active-low
scan_idx  output  2  digit currently in its BLANK/SCAN visit
frame_done  output  1  one-clk pulse at each commit

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. All state resets on assertion and is released synchronously to clk.
- Reset values:
  - Wx=4'b1111, display=7'b1111111, frame_done=0, scan_idx=0.
  - State BLANK, prescaler=0, phase counter=0.
  - Shadow and active: data=0, blank=1. dirty=0.
  - wr_ready=1.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick is a one-clk pulse on the clock where the count equals TICK_DIV-1.
- FSM, two states; the phase counter counts ticks and clears on every transition:
  - BLANK: lasts BLANK_TICKS ticks, then goes to SCAN with the same scan_idx.
  - SCAN: lasts ON_TICKS ticks. If scan_idx<3, increment scan_idx and go to BLANK.
  - SCAN with scan_idx==3: this is the frame end. Wrap scan_idx to 0, go to BLANK, and perform a commit on that same clock.
- Frame length = 4*(BLANK_TICKS+ON_TICKS)*TICK_DIV clk.
- Commit:
  - If dirty, copy shadow to active and clear dirty.
  - frame_done pulses for that one clk whether or not dirty was set.
  - wr_ready=0 only on the commit clk. wr_valid while wr_ready=0 is ignored, and the requester holds its request.
- Write: when wr_valid&&wr_ready, shadow[wr_addr] <= {wr_blank,wr_data} and dirty<=1. Repeated writes to the same address: the last one wins.
- Outputs are registered and reflect the FSM state one clk after the transition clk:
  - In BLANK: Wx=4'b1111, display=7'b1111111.
  - In SCAN: Wx = all ones with bit scan_idx low.
  - In SCAN, display is chosen in priority order:
    1. lamp_test=1 -> 7'b0000000.
    2. active blank=1 -> 7'b1111111, with Wx still asserted.
    3. otherwise the hex decode of active data.
- Hex decode (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Wx never has more than one bit low, and never changes directly from one low bit to another. A BLANK clk always intervenes.
- Reset mid-frame: outputs go dark immediately (asynchronous), all written data is lost, and scanning restarts at digit 0 BLANK.
- lamp_test is sampled each clk. It has no effect on Wx or timing.

Decomposition:
- Shared package seg7_pkg holds:
  - the 16 active-low segment constants;
  - SEG_OFF=7'b1111111 and SEG_ALL=7'b0000000;
  - WX_OFF=4'b1111;
  - the FSM state encoding (BLANK=0, SCAN=1).
- One combinational sub-module, hex_to_seg7 (4-bit in, 7-bit active-low out), reused elsewhere.

Test Plan:
All scenarios use TICK_DIV=4, ON_TICKS=3, BLANK_TICKS=1; frame = 64 clk.
1. Reset release, no writes -> Wx=1111 during every BLANK. During each SCAN, Wx steps 1110,1101,1011,0111, each low for 12 clk, with display=1111111 throughout. frame_done pulses every 64 clk.
2. Write addr0..3 = 1,2,3,F (blank=0) mid-frame -> the current frame is unchanged. From the next frame, display is 1111001, 0100100, 0110000, 0001110 on Wx 1110, 1101, 1011, 0111 respectively.
3. wr_valid held high on the commit clk -> wr_ready=0 for exactly that clk. The write is accepted on the next clk and shows one frame later.
4. Two writes to addr2 (5 then 7) in one frame -> the next frame shows 1111000 on Wx=1011.
5. lamp_test=1 with addr1 blank=1 -> display=0000000 in every SCAN, including digit 1. BLANK gaps remain 1111111/1111.
6. rst_n low mid-SCAN on digit 2 -> Wx=1111 and display=1111111 in the same cycle without waiting for clk. After release, scan_idx=0 and every digit is dark (blank=1) until a new write commits.
